// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port, with a
// pending-write scoreboard used by issue logic to detect read-after-write hazards.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rf_we,
  output logic [4:0]              rf_rd,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rd,
  input  logic [4:0]              chk_rs1,
  input  logic [4:0]              chk_rs2,
  output logic                    hazard,
  output logic [31:0]             pending
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant_idx;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_commit;
  logic [31:0]     pending_next;

  // Search starts one past the last served index; the grant depends only on
  // req_valid and last_grant, so a withdrawn request can never stall the port.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    xfer      = 1'b0;
    grant_idx = last_grant;
    sel_rd    = '0;
    sel_data  = '0;
    req_ready = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!xfer && req_valid[idx]) begin
        xfer      = 1'b1;
        grant_idx = idx[IW-1:0];
        sel_rd    = req_rd[5*idx +: 5];
        sel_data  = req_data[XLEN*idx +: XLEN];
      end
    end
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  assign wr_commit = xfer && (sel_rd != 5'd0);

  // Set is applied after clear so a newer issue to the same register wins.
  always_comb begin
    pending_next = pending;
    if (wr_commit) pending_next[sel_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) pending_next[iss_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(NUM_REQ - 1);
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      pending    <= '0;
    end else begin
      rf_we   <= wr_commit;
      pending <= pending_next;
      if (xfer) last_grant <= grant_idx;
      if (wr_commit) begin
        rf_rd    <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  assign hazard = ((chk_rs1 != 5'd0) && pending[chk_rs1]) ||
                  ((chk_rs2 != 5'd0) && pending[chk_rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter: arbitration order, write-back
// timing, x0 handling, scoreboard set/clear races and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hazard;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .hazard(hazard), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wdata;
    logic        e_haz;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] DA = 32'hA0A0_0001;
  localparam logic [31:0] DB = 32'hB0B0_0002;
  localparam logic [31:0] DC = 32'hC0C0_0003;
  localparam logic [31:0] DE = 32'hDEAD_BEEF;
  localparam logic [31:0] B7 = 32'h0000_0080;
  localparam logic [31:0] B9 = 32'h0000_0200;
  localparam logic [31:0] B12 = 32'h0000_1000;

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [14:0] rd, input logic [95:0] data,
    input logic iv, input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [2:0] e_ready, input logic e_we, input logic [4:0] e_rd,
    input logic [31:0] e_wdata, input logic e_haz, input logic [31:0] e_pend);
    vec_t v;
    v.valid = valid; v.rd = rd; v.data = data; v.iv = iv; v.ird = ird;
    v.rs1 = rs1; v.rs2 = rs2; v.e_ready = e_ready; v.e_we = e_we; v.e_rd = e_rd;
    v.e_wdata = e_wdata; v.e_haz = e_haz; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

    // Reset held with random activity: nothing may leak through.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 3'($urandom); req_rd = 15'($urandom);
      req_data  = {$urandom, $urandom, $urandom};
      iss_valid = 1'b1; iss_rd = 5'($urandom_range(1, 31));
      chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom);
      #1;
      check("rst_we", 32'(rf_we), 32'd0);
      check("rst_pending", pending, 32'd0);
    end
    @(negedge clk);
    drive_idle();
    #1;
    check("rst_ready_idle", 32'(req_ready), 32'd0);
    check("rst_rd", 32'(rf_rd), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Registered expectations reflect the state left by earlier vectors.
    vecs.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {DC,DB,DA}, 0,0,0,0, 3'b001, 0, 5'd0, 32'd0, 0, 32'd0));
    vecs.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {DC,DB,DA}, 0,0,0,0, 3'b010, 1, 5'd1, DA, 0, 32'd0));
    vecs.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {DC,DB,DA}, 0,0,0,0, 3'b100, 1, 5'd2, DB, 0, 32'd0));
    vecs.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {DC,DB,DA}, 0,0,0,0, 3'b001, 1, 5'd3, DC, 0, 32'd0));
    vecs.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {DC,DB,DA}, 0,0,0,0, 3'b010, 1, 5'd1, DA, 0, 32'd0));
    vecs.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {DC,DB,DA}, 0,0,0,0, 3'b100, 1, 5'd2, DB, 0, 32'd0));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 0,0,0,0, 3'b000, 1, 5'd3, DC, 0, 32'd0));
    vecs.push_back(mk(3'b010, {5'd0,5'd5,5'd0}, {32'd0,DE,32'd0}, 0,0,0,0, 3'b010, 0, 5'd3, DC, 0, 32'd0));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 0,0,0,0, 3'b000, 1, 5'd5, DE, 0, 32'd0));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 0,0,0,0, 3'b000, 0, 5'd5, DE, 0, 32'd0));
    // x0: transfer to rd=0 is consumed without a write
    vecs.push_back(mk(3'b001, 15'd0, {64'd0,32'h1111_1111}, 0,0,0,0, 3'b001, 0, 5'd5, DE, 0, 32'd0));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 1,5'd0,5'd0,5'd0, 3'b000, 0, 5'd5, DE, 0, 32'd0));
    // Scoreboard: issue rd=7, then write it back
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 1,5'd7,5'd0,5'd7, 3'b000, 0, 5'd5, DE, 0, 32'd0));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 0,5'd0,5'd0,5'd7, 3'b000, 0, 5'd5, DE, 1, B7));
    vecs.push_back(mk(3'b100, {5'd7,5'd0,5'd0}, {32'h77,64'd0}, 0,0,5'd0,5'd7, 3'b100, 0, 5'd5, DE, 1, B7));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 0,0,5'd0,5'd7, 3'b000, 1, 5'd7, 32'h77, 0, 32'd0));
    // Same-register set and clear in one cycle: set wins
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 1,5'd7,5'd0,5'd0, 3'b000, 0, 5'd7, 32'h77, 0, 32'd0));
    vecs.push_back(mk(3'b001, {5'd0,5'd0,5'd7}, {64'd0,32'h7070}, 1,5'd7,5'd7,5'd0, 3'b001, 0, 5'd7, 32'h77, 1, B7));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 0,0,5'd7,5'd0, 3'b000, 1, 5'd7, 32'h7070, 1, B7));
    // Different-register set and clear in one cycle: both apply
    vecs.push_back(mk(3'b010, {5'd0,5'd7,5'd0}, {32'd0,32'h7171,32'd0}, 1,5'd9,5'd7,5'd0, 3'b010, 0, 5'd7, 32'h7070, 1, B7));
    vecs.push_back(mk(3'b000, 15'd0, 96'd0, 0,0,5'd9,5'd7, 3'b000, 1, 5'd7, 32'h7171, 1, B9));

    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = vecs[i].valid; req_rd = vecs[i].rd; req_data = vecs[i].data;
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
      chk_rs1 = vecs[i].rs1; chk_rs2 = vecs[i].rs2;
      #1;
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_hazard", i), 32'(hazard), 32'(vecs[i].e_haz));
      check($sformatf("v%0d_pending", i), pending, vecs[i].e_pend);
    end

    // Async reset while a write is on the port: last_grant=1, so requester 0 wins.
    @(negedge clk);
    drive_idle();
    req_valid = 3'b001; req_rd = {10'd0, 5'd9}; req_data = {64'd0, 32'h9999_9999};
    iss_valid = 1'b1; iss_rd = 5'd12;
    #1;
    check("ar_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    drive_idle();
    check("ar_we_before", 32'(rf_we), 32'd1);
    check("ar_rd_before", 32'(rf_rd), 32'd9);
    check("ar_pending_before", pending, B12);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_we_after", 32'(rf_we), 32'd0);
    check("ar_pending_after", pending, 32'd0);
    check("ar_rd_after", 32'(rf_rd), 32'd0);
    check("ar_wdata_after", rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    #1;
    check("ar_ready_prio", 32'(req_ready), 32'd1);
    @(negedge clk);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
